fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction fetch front end placed between the instruction memory port and the core's decode input.
//   Generates sequential fetch addresses and issues pipelined requests (valid/ready) to instruction memory.
//   Accepts in-order responses of arbitrary latency and buffers {pc, instr} in a prefetch FIFO.
//   Presents instructions to decode over valid/ready; handles branch/jump redirects by flushing and discarding stale responses.
// PARAMETERS
//   RESET_PC         32'h0000_0000  first fetch address after reset
//   FIFO_DEPTH       4              prefetch FIFO entries (power of 2, >=2)
//   MAX_OUTSTANDING  2              max imem requests in flight (1..FIFO_DEPTH)
// PORTS
//   clk              in   1    clock, all state updates on rising edge
//   rst              in   1    synchronous active-high reset
//   redirect_valid   in   1    core requests fetch redirect (taken branch/jump)
//   redirect_pc      in   32   redirect target; bits [1:0] ignored (treated as 0)
//   imem_req_valid   out  1    request address valid
//   imem_req_ready   in   1    imem accepts request this cycle
//   imem_req_addr    out  32   word-aligned fetch address
//   imem_resp_valid  in   1    response data valid (responses return in request order)
//   imem_resp_data   in   32   instruction word
//   instr_valid      out  1    FIFO head valid to decode
//   instr_ready      in   1    decode consumes head this cycle
//   instr            out  32   head instruction (0 when instr_valid=0)
//   instr_pc         out  32   address of head instruction (0 when instr_valid=0)
//   fifo_count       out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//   - Reset (rst=1 at edge): fetch_pc=RESET_PC, resp_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0.
//     While rst=1: imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0, fifo_count=0.
//   - Credit rule: imem_req_valid = !rst && !redirect_valid && (outstanding < MAX_OUTSTANDING)
//     && (fifo_count + outstanding - drop_cnt < FIFO_DEPTH). Guarantees a slot for every live response.
//   - imem_req_addr = fetch_pc. Handshake (valid&&ready): outstanding+1, fetch_pc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0).
//     valid is held with a stable address until ready or redirect.
//   - Response: outstanding-1. If drop_cnt>0: discard, drop_cnt-1.
//     Else push {resp_pc, data} and resp_pc += 4. Push visible (instr_valid=1) the cycle after imem_resp_valid.
//   - Simultaneous issue and response in the same cycle: outstanding unchanged.
//     Simultaneous push and pop: count unchanged (legal even when full-1 or full).
//   - Pop on instr_valid && instr_ready; instr/instr_pc come from the registered FIFO head.
//   - Redirect (redirect_valid=1 at edge): FIFO cleared (a pop the same cycle is accepted and discarded with it).
//     fetch_pc=resp_pc={redirect_pc[31:2],2'b00}.
//     drop_cnt = outstanding - (imem_resp_valid ? 1 : 0), i.e. in-flight requests not yet returned.
//     A same-cycle response is discarded. No request is issued in the redirect cycle.
//     Next cycle: instr_valid=0; new request may issue.
//   - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time from outstanding.
//   - imem_resp_valid with outstanding==0 is a protocol error: ignore it (no push, counters unchanged).
//   - Reset mid-operation clears everything immediately. Responses that arrive after reset are ignored (outstanding=0).
//   - Steady state with zero-wait imem (ready=1, response 1 cycle after accept, decode always ready): one instruction per cycle.
//     First instr_valid two cycles after the first request accept.
// TESTING
//   1. Reset, RESET_PC=0, 1-cycle imem, instr_ready=1 -> instr_pc sequence 0,4,8,C on consecutive cycles; first valid 2 cycles after first accept.
//   2. instr_ready=0 for 10 cycles -> fifo_count saturates at 4. imem_req_valid drops once count+outstanding=4.
//      No FIFO overflow; releasing ready yields 0,4,8,C,10 in order.
//   3. imem latency 3 cycles, MAX_OUTSTANDING=2: redirect to 0x100 with 2 in flight -> both stale responses dropped.
//      Next instr_pc=0x100 and no instruction from the old path is delivered.
//   4. Redirect in same cycle as a response and as instr_ready pop -> response and head discarded.
//      drop_cnt=outstanding-1; following stream starts at target.
//   5. redirect_pc=0x203 -> fetch resumes at 0x200. Fetch at 0xFFFF_FFFC -> next addr wraps to 0x0000_0000.
//   6. Assert rst for 1 cycle mid-stream with 2 outstanding -> outputs zero during reset.
//      Late responses ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch front end between the instruction memory port and the
//   decode input. It walks a sequential fetch PC and issues pipelined requests
//   to imem. In-order responses of any latency are buffered as {pc, instr} in a
//   small prefetch FIFO that feeds decode. A redirect (taken branch/jump)
//   flushes the FIFO, retargets both PCs and arranges for responses that are
//   still in flight to be thrown away when they return.
//
//   Handshake rule used on every valid/ready pair in this block: a transfer
//   happens on a rising edge where valid && ready are both high. A source
//   holding valid keeps its payload stable until the transfer happens, except
//   that a redirect or reset may withdraw an imem request.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   redirect_valid/pc  fetch redirect request and target (pc[1:0] ignored)
//   imem_req_*         request channel to instruction memory (valid/ready/addr)
//   imem_resp_*        in-order response channel from instruction memory
//   instr_valid/ready  instruction channel to decode
//   instr, instr_pc    FIFO head word and its address (0 when not valid)
//   fifo_count         current prefetch FIFO occupancy
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  output logic                          imem_req_valid,
  input  logic                          imem_req_ready,
  output logic [31:0]                   imem_req_addr,
  input  logic                          imem_resp_valid,
  input  logic [31:0]                   imem_resp_data,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic [31:0]                   instr,
  output logic [31:0]                   instr_pc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  // Architectural state
  logic [31:0]      r_fetch_pc;      // address of the next request to issue
  logic [31:0]      r_resp_pc;       // address belonging to the next live response
  logic [31:0]      r_fifo_pc    [FIFO_DEPTH];
  logic [31:0]      r_fifo_instr [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [OUT_W-1:0] r_outstanding;   // requests accepted by imem, not yet answered
  logic [OUT_W-1:0] r_drop_cnt;      // of those, how many belong to a dead path

  // Datapath / control wires
  logic [31:0]      w_redirect_target;
  logic [31:0]      w_live_slots;
  logic             w_credit_ok;
  logic             w_req_valid;
  logic             w_issue;
  logic             w_resp_take;
  logic             w_push;
  logic             w_head_valid;
  logic             w_pop;

  // Masking rather than slicing keeps the whole redirect_pc bus in use.
  assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;

  // Slots that will eventually be occupied: entries already buffered plus
  // live (non-dropped) requests still in flight. Issuing only while this is
  // below the depth means every live response is guaranteed a FIFO slot, so
  // the response channel never needs back-pressure.
  assign w_live_slots = 32'(r_count) + 32'(r_outstanding) - 32'(r_drop_cnt);
  assign w_credit_ok  = (32'(r_outstanding) < 32'(MAX_OUTSTANDING)) &&
                        (w_live_slots < 32'(FIFO_DEPTH));

  // No request in a redirect cycle: fetch_pc is about to change under it.
  assign w_req_valid = !rst && !redirect_valid && w_credit_ok;
  assign w_issue     = w_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_resp_take = !rst && imem_resp_valid && (r_outstanding != '0);

  // A response is buffered only if it belongs to the current path and no
  // redirect is killing the FIFO this very cycle.
  assign w_push = w_resp_take && (r_drop_cnt == '0) && !redirect_valid;

  assign w_head_valid = !rst && (r_count != '0);
  assign w_pop        = w_head_valid && instr_ready;

  // Outputs
  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign instr_valid    = w_head_valid;
  assign instr          = w_head_valid ? r_fifo_instr[r_rd_ptr] : 32'h0;
  assign instr_pc       = w_head_valid ? r_fifo_pc[r_rd_ptr]    : 32'h0;
  assign fifo_count     = rst ? '0 : r_count;

  // Control state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      if (redirect_valid) begin
        r_fetch_pc <= w_redirect_target;
        r_resp_pc  <= w_redirect_target;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        // Everything still in flight after this edge is from the old path.
        // A response arriving right now is already consumed (and discarded).
        r_drop_cnt <= w_resp_take ? (r_outstanding - OUT_W'(1)) : r_outstanding;
      end else begin
        if (w_issue) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_push) begin
          r_resp_pc <= r_resp_pc + 32'd4;
          r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
          r_count <= r_count - CNT_W'(1);
        end
        if (w_resp_take && (r_drop_cnt != '0)) begin
          r_drop_cnt <= r_drop_cnt - OUT_W'(1);
        end
      end

      // w_issue is already 0 in a redirect cycle, so this covers both cases.
      if (w_issue && !w_resp_take) begin
        r_outstanding <= r_outstanding + OUT_W'(1);
      end else if (w_resp_take && !w_issue) begin
        r_outstanding <= r_outstanding - OUT_W'(1);
      end
    end
  end

  // FIFO storage. Data needs no reset: occupancy alone decides validity.
  // When full, a push and a pop in the same cycle hit the same slot; the head
  // is read combinationally before the edge, so the overwrite is safe.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]    <= r_resp_pc;
      r_fifo_instr[r_wr_ptr] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage (RESET_PC=0, FIFO_DEPTH=4,
//   MAX_OUTSTANDING=2). A behavioural imem with programmable latency answers
//   accepted requests in order with mem_word(addr). Each test pushes the
//   {pc, instr} pairs that decode must see into exp_q; an independent monitor
//   pops and compares on every decode handshake.
//   Timing: inputs change at negedge, imem response at negedge+1, all
//   sampling at negedge+4 (one time unit before the rising edge).
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [2:0]  fifo_count;

  fetch_stage #(
    .RESET_PC        (32'h0000_0000),
    .FIFO_DEPTH      (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .fifo_count      (fifo_count)
  );

  // ---------------- clock / cycle counter ----------------
  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_q[$];

  // imem model state
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          lat = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_q.push_back({pc, mem_word(pc)});
  endtask

  // Wait (from a negedge) until every expected instruction was delivered,
  // then stop consuming at the following negedge.
  task automatic drain(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (exp_q.size() != 0 && n < 200);
    instr_ready = 1'b0;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Wait until imem has nothing in flight for three consecutive cycles.
  task automatic quiesce(input string name);
    int n;
    int quiet;
    n = 0;
    quiet = 0;
    while (quiet < 3 && n < 100) begin
      @(negedge clk);
      n++;
      if (pend_addr.size() == 0) quiet++;
      else quiet = 0;
    end
    check(name, (quiet >= 3) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // ---------------- imem model ----------------
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
      end
      #3;
      if (imem_req_valid === 1'b1 && imem_req_ready) begin
        pend_addr.push_back(imem_req_addr);
        pend_due.push_back(cyc + lat);
      end
    end
  end

  // ---------------- monitor ----------------
  // A pop in a redirect cycle is flushed along with the FIFO, so decode
  // ignores it and so does the monitor.
  initial forever begin
    logic [63:0] got;
    logic [63:0] e;
    @(negedge clk);
    #4;
    if (instr_valid === 1'b1 && instr_ready && !redirect_valid) begin
      got = {instr_pc, instr};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_instr: got pc %08h instr %08h, none expected", instr_pc, instr);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL decode_stream: got pc %08h instr %08h expected pc %08h instr %08h",
                   got[63:32], got[31:0], e[63:32], e[31:0]);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int first_acc;
    int first_v;
    int valid_run;
    int max_cnt;
    bit ok;

    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b0;

    // Test 1: reset state, then streaming with a 1-cycle imem
    repeat (2) @(negedge clk);
    #4;
    check("rst_req_valid",   32'(imem_req_valid), 32'd0);
    check("rst_instr_valid", 32'(instr_valid),    32'd0);
    check("rst_instr",       instr,               32'd0);
    check("rst_instr_pc",    instr_pc,            32'd0);
    check("rst_fifo_count",  32'(fifo_count),     32'd0);

    @(negedge clk);
    rst         = 1'b0;
    lat         = 1;
    instr_ready = 1'b1;
    for (int k = 0; k < 8; k++) expect_pc(32'(k * 4));
    #4;
    check("t1_first_addr", imem_req_addr, 32'h0);
    first_acc = -1;
    first_v   = -1;
    valid_run = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #4;
      end
      if (first_acc < 0 && imem_req_valid === 1'b1 && imem_req_ready) first_acc = cyc;
      if (instr_valid === 1'b1) begin
        if (first_v < 0) first_v = cyc;
        valid_run++;
      end
    end
    check("t1_first_valid_latency", 32'(first_v - first_acc), 32'd2);
    check("t1_valid_every_cycle",   32'(valid_run),           32'd8);
    drain("t1_drain");

    // Test 2: decode stalled, FIFO saturates without overflow
    quiesce("t2_quiesce");
    @(negedge clk);
    rst = 1'b1;
    #4;
    check("t2_rst_fifo_count",  32'(fifo_count),  32'd0);
    check("t2_rst_instr_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    max_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      #4;
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    end
    check("t2_max_count",   32'(max_cnt),        32'd4);
    check("t2_full_count",  32'(fifo_count),     32'd4);
    check("t2_req_stalled", 32'(imem_req_valid), 32'd0);
    for (int k = 0; k < 6; k++) expect_pc(32'(k * 4));
    @(negedge clk);
    instr_ready = 1'b1;
    drain("t2_drain");

    // Test 3: 3-cycle imem, redirect with two requests in flight
    quiesce("t3_quiesce");
    @(negedge clk);
    lat            = 3;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (pend_addr.size() == 2) ok = 1'b1;
      else @(negedge clk);
    end
    check("t3_two_inflight", 32'(ok), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    for (int k = 0; k < 4; k++) expect_pc(32'h100 + 32'(k * 4));
    @(negedge clk);
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    #4;
    check("t3_addr_after_redirect", imem_req_addr,    32'h100);
    check("t3_valid_after_redirect", 32'(instr_valid), 32'd0);
    drain("t3_drain");

    // Test 4: redirect colliding with a response and a decode pop
    quiesce("t4_quiesce");
    @(negedge clk);
    lat            = 2;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    @(negedge clk);
    redirect_valid = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (pend_addr.size() == 2 && pend_due[0] <= cyc && instr_valid === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    check("t4_collision_setup", 32'(ok), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h500;
    instr_ready    = 1'b1;
    for (int k = 0; k < 4; k++) expect_pc(32'h500 + 32'(k * 4));
    @(negedge clk);
    redirect_valid = 1'b0;
    #4;
    check("t4_valid_after_redirect", 32'(instr_valid),    32'd0);
    check("t4_req_after_redirect",   32'(imem_req_valid), 32'd1);
    check("t4_addr_after_redirect",  imem_req_addr,       32'h500);
    drain("t4_drain");

    // Test 5a: unaligned redirect target
    quiesce("t5a_quiesce");
    @(negedge clk);
    lat            = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    for (int k = 0; k < 3; k++) expect_pc(32'h200 + 32'(k * 4));
    @(negedge clk);
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    #4;
    check("t5_aligned_addr", imem_req_addr, 32'h200);
    drain("t5a_drain");

    // Test 5b: fetch address wraps past 0xFFFF_FFFC
    quiesce("t5b_quiesce");
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    expect_pc(32'hFFFF_FFF8);
    expect_pc(32'hFFFF_FFFC);
    expect_pc(32'h0000_0000);
    expect_pc(32'h0000_0004);
    @(negedge clk);
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    drain("t5b_drain");

    // Test 6: reset mid-stream with two in flight and a non-empty FIFO
    quiesce("t6_quiesce");
    @(negedge clk);
    lat            = 3;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h600;
    @(negedge clk);
    redirect_valid = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (pend_addr.size() == 2 && instr_valid === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    check("t6_setup", 32'(ok), 32'd1);
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    #4;
    check("t6_rst_req_valid",   32'(imem_req_valid), 32'd0);
    check("t6_rst_instr_valid", 32'(instr_valid),    32'd0);
    check("t6_rst_instr",       instr,               32'd0);
    check("t6_rst_instr_pc",    instr_pc,            32'd0);
    check("t6_rst_fifo_count",  32'(fifo_count),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    ok  = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (pend_addr.size() == 0) ok = 1'b1;
    end
    @(negedge clk);
    #4;
    check("t6_late_resp_drained",  32'(ok),             32'd1);
    check("t6_late_resp_ignored",  32'(fifo_count),     32'd0);
    check("t6_restart_addr",       imem_req_addr,       32'h0);
    check("t6_restart_req_valid",  32'(imem_req_valid), 32'd1);
    @(negedge clk);
    lat            = 1;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    for (int k = 0; k < 4; k++) expect_pc(32'(k * 4));
    drain("t6_drain");

    repeat (3) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
